// File: rtl/narrow_mult_sequencer_pkg.sv
// Shared definitions for the narrow-array sequenced multiplier: FSM states,
// default geometry and the chunk-count / counter-width helpers.
package narrow_mult_sequencer_pkg;

  localparam int DEFAULT_WIDTH  = 64;
  localparam int DEFAULT_NARROW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int chunk_count(input int width, input int narrow);
    return width / narrow;
  endfunction

  // Counter needs at least one bit even when a single chunk covers the operand.
  function automatic int count_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  localparam int K     = chunk_count(DEFAULT_WIDTH, DEFAULT_NARROW);
  localparam int CNT_W = count_width(K);

endpackage

// File: rtl/narrow_mult_sequencer_if.sv
// Operand/result handshake bundle between an operand source (master) and
// the sequenced multiplier (slave).
interface narrow_mult_sequencer_if
  import narrow_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   x;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, x, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, x, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/narrow_mult_sequencer_array_mult.sv
// Generic unsigned M x N combinational array multiplier: one shifted
// multiplicand row per multiplier bit, summed down the array.
module narrow_mult_sequencer_array_mult #(
  parameter int M = 16,
  parameter int N = 16
) (
  output logic [M+N-1:0] prod,
  input  logic [M-1:0]   mcand,
  input  logic [N-1:0]   mplier
);

  logic [M+N-1:0] row_base;

  always_comb begin
    row_base = '0;
    row_base[M-1:0] = mcand;
    prod = '0;
    for (int r = 0; r < N; r++) begin
      if (mplier[r]) begin
        prod = prod + (row_base << r);
      end
    end
  end

endmodule

// File: rtl/narrow_mult_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier that walks every chunk pair
// through one NARROW x NARROW array and accumulates the shifted partials.
module narrow_mult_sequencer
  import narrow_mult_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NARROW = DEFAULT_NARROW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  narrow_mult_sequencer_if.slave bus
);

  localparam int             NUM_CHUNKS = chunk_count(WIDTH, NARROW);
  localparam int             CW         = count_width(NUM_CHUNKS);
  localparam int             PW         = 2 * WIDTH;
  localparam logic [CW-1:0]  LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  if (((WIDTH % NARROW) != 0) || (NARROW < 2)) begin : g_param_check
    $fatal(1, "narrow_mult_sequencer: WIDTH must be a multiple of NARROW and NARROW >= 2");
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       i_q, i_d;
  logic [CW-1:0]       j_q, j_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [PW-1:0]       acc_q, acc_d;

  logic [NARROW-1:0]   a_chunk;
  logic [NARROW-1:0]   x_chunk;
  logic [2*NARROW-1:0] pp;
  logic [PW-1:0]       pp_ext;
  logic [PW-1:0]       pp_shifted;

  always_comb begin
    a_chunk = a_q[int'(i_q)*NARROW +: NARROW];
    x_chunk = x_q[int'(j_q)*NARROW +: NARROW];
  end

  narrow_mult_sequencer_array_mult #(
    .M(NARROW),
    .N(NARROW)
  ) u_array (
    .prod   (pp),
    .mcand  (a_chunk),
    .mplier (x_chunk)
  );

  // Chunk pair (i, j) carries weight 2^((i+j)*NARROW) in the full product.
  always_comb begin
    pp_ext = '0;
    pp_ext[2*NARROW-1:0] = pp;
    pp_shifted = pp_ext << ((int'(i_q) + int'(j_q)) * NARROW);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    x_d     = x_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          x_d     = bus.x;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST_CHUNK) begin
          j_d = '0;
          if (i_q == LAST_CHUNK) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.p         = acc_q;

endmodule

// File: tb/tb_narrow_mult_sequencer.sv
// Self-checking bench for narrow_mult_sequencer: random and directed operands
// compared against a plain a*x reference with fixed-latency expectations.
module tb_narrow_mult_sequencer;

  localparam int WIDTH      = 64;
  localparam int NARROW     = 16;
  localparam int LATENCY    = 16;
  localparam int INTERVAL   = 18;
  localparam int WAIT_LIMIT = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  narrow_mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

  narrow_mult_sequencer #(
    .WIDTH  (WIDTH),
    .NARROW (NARROW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] refProduct(input logic [63:0] av, input logic [63:0] xv);
    logic [127:0] wa;
    logic [127:0] wx;
    wa = {64'd0, av};
    wx = {64'd0, xv};
    return wa * wx;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction; inputs are scrambled during RUN since they must be ignored.
  task automatic applyStimulus(input logic [63:0] av, input logic [63:0] xv,
                               input string tag, input bit release_after);
    int n;
    bus.a        = av;
    bus.x        = xv;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    checkOutput({tag, " ready before accept"}, bus.in_ready, 128'd1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput({tag, " run flags"}, {bus.out_valid, bus.in_ready, bus.busy}, 128'b001);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < WAIT_LIMIT) begin
      bus.a         = rand64();
      bus.x         = rand64();
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput({tag, " latency"}, 128'(n), 128'(LATENCY));
    checkOutput({tag, " product"}, bus.p, refProduct(av, xv));
    if (release_after) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checkOutput({tag, " released"}, {bus.out_valid, bus.in_ready, bus.busy}, 128'b010);
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0]  a1, x1, a2, x2;
    logic [127:0] held;
    int           n;
    int           accept_cycle;
    int           prev_accept;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.x         = '0;
    rst_n         = 1'b0;

    repeat (3) tick();
    checkOutput("reset flags", {bus.in_ready, bus.out_valid, bus.busy}, 128'b100);
    checkOutput("reset p", bus.p, 128'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset flags", {bus.in_ready, bus.out_valid, bus.busy}, 128'b100);

    applyStimulus(64'd3, 64'd5, "small", 1'b1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "all-ones", 1'b1);
    applyStimulus(64'd0, rand64(), "a zero", 1'b1);
    applyStimulus(rand64(), 64'd0, "x zero", 1'b1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(rand64(), rand64(), $sformatf("random %0d", k), 1'b1);
    end

    // Backpressure: a new request waits behind an unconsumed result.
    a1 = rand64();
    x1 = rand64();
    applyStimulus(a1, x1, "bp first", 1'b0);
    held = refProduct(a1, x1);
    a2 = rand64();
    x2 = rand64();
    bus.a         = a2;
    bus.x         = x2;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("bp hold flags", {bus.out_valid, bus.in_ready, bus.busy}, 128'b101);
      checkOutput("bp hold p", bus.p, held);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp back to idle", {bus.in_ready, bus.out_valid}, 128'b10);
    applyStimulus(a2, x2, "bp held request", 1'b1);

    // Reset during the RUN iterations must clear outputs without a clock edge.
    bus.a        = rand64() | 64'h1;
    bus.x        = rand64() | 64'h1;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset flags", {bus.in_ready, bus.out_valid, bus.busy}, 128'b100);
    checkOutput("mid-run reset p", bus.p, 128'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("after mid-run reset", {bus.in_ready, bus.out_valid, bus.busy}, 128'b100);
    applyStimulus(64'd1 << 32, 64'd1 << 32, "2^32 squared", 1'b1);

    // Back-to-back sweep with in_valid and out_ready held high.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    prev_accept   = -1;
    for (int ai = 1; ai <= 64; ai++) begin
      for (int xi = 1; xi <= 64; xi += 3) begin
        bus.a = 64'(ai);
        bus.x = 64'(xi);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < WAIT_LIMIT) begin
          tick();
          n++;
        end
        accept_cycle = cycle;
        if (prev_accept >= 0) begin
          checkOutput("sweep interval", 128'(accept_cycle - prev_accept), 128'(INTERVAL));
        end
        prev_accept = accept_cycle;
        tick();
        bus.a = rand64();
        bus.x = rand64();
        n = 0;
        while (bus.out_valid !== 1'b1 && n < WAIT_LIMIT) begin
          tick();
          n++;
        end
        checkOutput($sformatf("sweep %0d*%0d", ai, xi), bus.p, refProduct(64'(ai), 64'(xi)));
        tick();
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
